// File: rtl/gpio_data_in.sv
// GPIO input block: 2-flop synchroniser, per-bit debounce filter, sticky
// rise/fall event flags with write-1-to-clear, and a strobed snapshot read.
module gpio_data_in #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_pins,
  input  logic             read_enable,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [WIDTH-1:0] edge_status,
  output logic             irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] filt_reg;
  logic [WIDTH-1:0] filt_next;
  logic [WIDTH-1:0] set_evt;
  logic [WIDTH-1:0] edge_reg;
  logic [WIDTH-1:0] edge_next;
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      filt_reg  <= '0;
    end else begin
      sync1_reg <= gpio_pins;
      sync2_reg <= sync1_reg;
      filt_reg  <= filt_next;
    end
  end

  // A bit only follows sync2 once it has disagreed for DEBOUNCE_CYCLES samples in a row.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          differ;
      logic          at_last;

      assign differ        = sync2_reg[gi] ^ filt_reg[gi];
      assign at_last       = (cnt_reg == CNT_LAST);
      assign cnt_next      = (differ && !at_last) ? cnt_reg + CW'(1) : '0;
      assign filt_next[gi] = (differ && at_last) ? sync2_reg[gi] : filt_reg[gi];

      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  // Set has priority over the clear strobe on the same bit.
  assign set_evt   = (filt_next & ~filt_reg & rise_en) | (~filt_next & filt_reg & fall_en);
  assign edge_next = set_evt | (edge_reg & ~irq_clear);

  always_ff @(posedge clk) begin
    if (!reset) begin
      edge_reg  <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      edge_reg  <= edge_next;
      valid_reg <= read_enable;
      if (read_enable) begin
        data_reg <= filt_reg;
      end
    end
  end

  assign data_out    = data_reg;
  assign data_valid  = valid_reg;
  assign edge_status = edge_reg;
  assign irq         = |edge_reg;

endmodule

// File: tb/tb_gpio_data_in.sv
// Self-checking bench for gpio_data_in: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the GPIO input block.
module tb_gpio_data_in;
  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] gpio_pins = '0;
  logic         read_enable = 1'b0;
  logic [W-1:0] rise_en = '0;
  logic [W-1:0] fall_en = '0;
  logic [W-1:0] irq_clear = '0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic [W-1:0] edge_status;
  logic         irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpio_data_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .gpio_pins   (gpio_pins),
    .read_enable (read_enable),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .irq_clear   (irq_clear),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .edge_status (edge_status),
    .irq         (irq)
  );

  // Reference model: pins are seen two samples late; a filtered bit adopts the
  // seen value after D consecutive disagreeing samples.
  logic [W-1:0] m_s1, m_s2, m_filt, m_edge, m_dout, m_nf;
  logic         m_valid;
  int           m_run[W];
  int           m_run_next[W];

  always_comb begin
    m_nf = m_filt;
    for (int i = 0; i < W; i++) begin
      m_run_next[i] = 0;
      if (m_s2[i] != m_filt[i]) begin
        if (m_run[i] + 1 >= D) m_nf[i] = m_s2[i];
        else m_run_next[i] = m_run[i] + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_s1 <= '0; m_s2 <= '0; m_filt <= '0; m_edge <= '0; m_dout <= '0; m_valid <= 1'b0;
      for (int i = 0; i < W; i++) m_run[i] <= 0;
    end else begin
      m_s1    <= gpio_pins;
      m_s2    <= m_s1;
      m_filt  <= m_nf;
      m_edge  <= (m_nf & ~m_filt & rise_en) | (~m_nf & m_filt & fall_en) | (m_edge & ~irq_clear);
      m_valid <= read_enable;
      if (read_enable) m_dout <= m_filt;
      for (int i = 0; i < W; i++) m_run[i] <= m_run_next[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; gpio_pins = '1; rise_en = '0; fall_en = '0;
    repeat (3) begin
      tick();
      vectors++;
      if ({data_out, data_valid, edge_status, irq} !== '0) begin
        miscompares++;
        $display("FAIL reset_hold: got dout=%h valid=%b edge=%h irq=%b, want all 0", data_out, data_valid, edge_status, irq);
      end
    end
    reset = 1'b1;
    repeat (6) begin
      tick();
      vectors++;
      if ({data_out, data_valid, edge_status, irq} !== {m_dout, m_valid, m_edge, |m_edge}) begin
        miscompares++;
        $display("FAIL reset_release: got dout=%h valid=%b edge=%h irq=%b, want dout=%h valid=%b edge=%h irq=%b",
                 data_out, data_valid, edge_status, irq, m_dout, m_valid, m_edge, |m_edge);
      end
    end
    read_enable = 1'b1; tick(); read_enable = 1'b0;
    vectors++;
    if (data_out !== 16'hFFFF || data_valid !== 1'b1 || edge_status !== 16'h0000) begin
      miscompares++;
      $display("FAIL read_after_release: got dout=%h valid=%b edge=%h, want dout=ffff valid=1 edge=0000", data_out, data_valid, edge_status);
    end
  endtask

  task automatic test_rise_latency();
    int first;
    gpio_pins = '0; rise_en = '0; fall_en = '0;
    repeat (8) tick();
    rise_en = 16'h0001; gpio_pins = 16'h0001;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      vectors++;
      if ({data_out, data_valid, edge_status, irq} !== {m_dout, m_valid, m_edge, |m_edge}) begin
        miscompares++;
        $display("FAIL rise_model k=%0d: got edge=%h irq=%b, want edge=%h irq=%b", k, edge_status, irq, m_edge, |m_edge);
      end
      if (first == 0 && edge_status[0] === 1'b1) first = k;
    end
    vectors++;
    if (first != 6 || edge_status !== 16'h0001 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL rise_latency: got first=%0d edge=%h irq=%b, want first=6 edge=0001 irq=1", first, edge_status, irq);
    end
  endtask

  task automatic test_glitch();
    rise_en = '1; fall_en = '1; irq_clear = '1;
    tick();
    irq_clear = '0;
    gpio_pins = 16'h0021;
    repeat (3) tick();
    gpio_pins = 16'h0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (edge_status !== 16'h0000 || irq !== 1'b0 || edge_status !== m_edge) begin
        miscompares++;
        $display("FAIL glitch k=%0d: got edge=%h irq=%b, want edge=0000 irq=0 (model %h)", k, edge_status, irq, m_edge);
      end
    end
    read_enable = 1'b1; tick(); read_enable = 1'b0;
    vectors++;
    if (data_out !== 16'h0001 || data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_filt: got dout=%h valid=%b, want dout=0001 valid=1", data_out, data_valid);
    end
  endtask

  task automatic test_read();
    rise_en = '0; fall_en = '0; gpio_pins = 16'hA5A5;
    repeat (8) tick();
    read_enable = 1'b1; tick(); read_enable = 1'b0;
    vectors++;
    if (data_out !== 16'hA5A5 || data_valid !== 1'b1 || data_out !== m_dout) begin
      miscompares++;
      $display("FAIL read_pulse: got dout=%h valid=%b, want dout=a5a5 valid=1", data_out, data_valid);
    end
    tick();
    vectors++;
    if (data_out !== 16'hA5A5 || data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL read_hold: got dout=%h valid=%b, want dout=a5a5 valid=0", data_out, data_valid);
    end
  endtask

  task automatic test_set_wins();
    rise_en = 16'h0001; fall_en = 16'h0001; gpio_pins = 16'hA5A4;
    repeat (6) tick();
    vectors++;
    if (edge_status !== 16'h0001 || edge_status !== m_edge) begin
      miscompares++;
      $display("FAIL fall_event: got edge=%h, want edge=0001", edge_status);
    end
    gpio_pins = 16'hA5A5;
    repeat (5) tick();
    irq_clear = 16'h0001; tick(); irq_clear = '0;
    vectors++;
    if (edge_status !== 16'h0001 || irq !== 1'b1 || edge_status !== m_edge) begin
      miscompares++;
      $display("FAIL set_wins: got edge=%h irq=%b, want edge=0001 irq=1", edge_status, irq);
    end
    repeat (2) tick();
    irq_clear = 16'h0001; tick(); irq_clear = '0;
    vectors++;
    if (edge_status !== 16'h0000 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL lone_clear: got edge=%h irq=%b, want edge=0000 irq=0", edge_status, irq);
    end
  endtask

  task automatic test_reset_mid();
    rise_en = '0; fall_en = '0; gpio_pins = '0;
    repeat (8) tick();
    rise_en = '1; fall_en = '1; gpio_pins = 16'h0008;
    repeat (4) tick();
    reset = 1'b0; gpio_pins = '0;
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (edge_status !== 16'h0000 || irq !== 1'b0 || edge_status !== m_edge) begin
        miscompares++;
        $display("FAIL reset_mid k=%0d: got edge=%h irq=%b, want edge=0000 irq=0", k, edge_status, irq);
      end
    end
    read_enable = 1'b1; tick(); read_enable = 1'b0;
    vectors++;
    if (data_out !== 16'h0000 || data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_filt: got dout=%h valid=%b, want dout=0000 valid=1", data_out, data_valid);
    end
  endtask

  task automatic test_back_to_back();
    rise_en = '0; fall_en = '0; gpio_pins = 16'h1234; read_enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (data_valid !== 1'b1 || data_out !== m_dout) begin
        miscompares++;
        $display("FAIL back_to_back k=%0d: got dout=%h valid=%b, want dout=%h valid=1", k, data_out, data_valid, m_dout);
      end
    end
    read_enable = 1'b0; tick();
    vectors++;
    if (data_valid !== 1'b0 || data_out !== 16'h1234) begin
      miscompares++;
      $display("FAIL back_to_back_end: got dout=%h valid=%b, want dout=1234 valid=0", data_out, data_valid);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) begin
        rise_en = 16'($urandom); fall_en = 16'($urandom);
      end
      if ($urandom % 6 == 0) gpio_pins = gpio_pins ^ (16'd1 << $urandom_range(0, 15));
      if ($urandom % 40 == 0) gpio_pins = gpio_pins ^ 16'($urandom);
      irq_clear   = ($urandom % 8 == 0) ? 16'($urandom) : 16'h0000;
      read_enable = ($urandom % 4 == 0);
      reset       = ($urandom % 500 != 0);
      tick();
      vectors++;
      if ({data_out, data_valid, edge_status, irq} !== {m_dout, m_valid, m_edge, |m_edge}) begin
        miscompares++;
        $display("FAIL random k=%0d: got dout=%h valid=%b edge=%h irq=%b, want dout=%h valid=%b edge=%h irq=%b",
                 k, data_out, data_valid, edge_status, irq, m_dout, m_valid, m_edge, |m_edge);
      end
    end
    reset = 1'b1; irq_clear = '0; read_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_read();
    test_set_wins();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
